// File: rtl/bsg_acm_addr_gen.sv
// bsg_acm_addr_gen
//
// Address sequencer for the ACM decryptor cell array. Each iteration sweeps
// the dim_p x dim_p destination image in raster order (x fastest). For every
// destination pixel (x, y) it presents the forward Arnold cat map source
// coordinate ((x + y) mod N, (x + 2y) mod N). Between iterations it emits a
// one-cycle swap pulse. After the final iteration it emits a one-cycle done
// pulse.
//
// Handshake: a pair is offered while v_o is high. It transfers on a rising
// clock edge where v_o & ready_i. While v_o & ~ready_i, every output and all
// internal state hold. v_o never depends combinationally on ready_i.
//
// Ports:
//   clk_i, reset_n_i          clock, synchronous active-low reset
//   start_i, iters_i          begin a run (IDLE only), iteration count
//   busy_o                    high in every state but IDLE
//   v_o, ready_i              address pair valid / consumer accept
//   dst_x_o, dst_y_o          destination (raster) coordinate
//   src_x_o, src_y_o          source coordinate from the cat map
//   last_pixel_o              current pair is (N-1, N-1)
//   swap_o, done_o            iteration boundary / end of run pulses
//   state_o                   FSM state, exposed for debug and checkers
module bsg_acm_addr_gen #(
  parameter int dim_p        = 32,
  parameter int iter_width_p = 8,
  localparam int coord_w_lp  = $clog2(dim_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    start_i,
  input  logic [iter_width_p-1:0] iters_i,
  output logic                    busy_o,
  output logic                    v_o,
  input  logic                    ready_i,
  output logic [coord_w_lp-1:0]   dst_x_o,
  output logic [coord_w_lp-1:0]   dst_y_o,
  output logic [coord_w_lp-1:0]   src_x_o,
  output logic [coord_w_lp-1:0]   src_y_o,
  output logic                    last_pixel_o,
  output logic                    swap_o,
  output logic                    done_o,
  output logic [1:0]              state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SWAP = 2'd2,
    DONE = 2'd3
  } state_e;

  // x + 2y reaches 3N-3, so two guard bits above the coordinate width.
  localparam int sw_lp = coord_w_lp + 2;
  localparam logic [sw_lp-1:0]      n_lp   = sw_lp'(dim_p);
  localparam logic [coord_w_lp-1:0] max_lp = coord_w_lp'(dim_p - 1);

  state_e                  state_r, state_n;
  logic [coord_w_lp-1:0]   x_r, x_n, y_r, y_n;
  logic [iter_width_p-1:0] iter_r, iter_n, iters_r, iters_n;

  logic [sw_lp-1:0] x_ext, y_ext, sum_x, sum_y;
  logic             at_last;

  // Source coordinate: the inputs to each sum are already < N, so x+y needs
  // one conditional subtraction and x+2y needs two. Exact for any N.
  always_comb begin
    x_ext = sw_lp'(x_r);
    y_ext = sw_lp'(y_r);
    sum_x = x_ext + y_ext;
    if (sum_x >= n_lp) sum_x = sum_x - n_lp;
    sum_y = x_ext + (y_ext << 1);
    if (sum_y >= n_lp) sum_y = sum_y - n_lp;
    if (sum_y >= n_lp) sum_y = sum_y - n_lp;
  end

  assign at_last = (x_r == max_lp) && (y_r == max_lp);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
      x_r     <= '0;
      y_r     <= '0;
      iter_r  <= '0;
      iters_r <= '0;
    end else begin
      state_r <= state_n;
      x_r     <= x_n;
      y_r     <= y_n;
      iter_r  <= iter_n;
      iters_r <= iters_n;
    end
  end

  always_comb begin
    state_n = state_r;
    x_n     = x_r;
    y_n     = y_r;
    iter_n  = iter_r;
    iters_n = iters_r;
    unique case (state_r)
      IDLE: begin
        if (start_i) begin
          iters_n = iters_i;
          x_n     = '0;
          y_n     = '0;
          iter_n  = '0;
          state_n = (iters_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // v_o is high throughout RUN, so ready_i alone marks a transfer.
        if (ready_i) begin
          if (at_last) begin
            // x/y are cleared here so DONE and SWAP present zero coordinates.
            x_n = '0;
            y_n = '0;
            if (iter_r == iters_r - iter_width_p'(1)) begin
              state_n = DONE;
            end else begin
              iter_n  = iter_r + iter_width_p'(1);
              state_n = SWAP;
            end
          end else if (x_r == max_lp) begin
            x_n = '0;
            y_n = y_r + coord_w_lp'(1);
          end else begin
            x_n = x_r + coord_w_lp'(1);
          end
        end
      end
      SWAP:    state_n = RUN;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy_o       = (state_r != IDLE);
  assign v_o          = (state_r == RUN);
  assign swap_o       = (state_r == SWAP);
  assign done_o       = (state_r == DONE);
  assign last_pixel_o = (state_r == RUN) && at_last;
  assign dst_x_o      = x_r;
  assign dst_y_o      = y_r;
  assign src_x_o      = sum_x[coord_w_lp-1:0];
  assign src_y_o      = sum_y[coord_w_lp-1:0];
  assign state_o      = state_r;

endmodule

// File: tb/tb_bsg_acm_addr_gen.sv
// Directed bench for bsg_acm_addr_gen. It uses two instances, with N=4 and
// N=5. Inputs are driven and outputs are sampled on the falling clock edge.
module tb_bsg_acm_addr_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n = 1'b0;
  logic       start   = 1'b0;
  logic       ready   = 1'b1;
  logic [7:0] iters_in = 8'd0;
  logic       sel     = 1'b0;  // 0: N=4 instance, 1: N=5 instance

  logic start4, start5;
  assign start4 = start & ~sel;
  assign start5 = start & sel;

  logic       busy4, v4, last4, swap4, done4;
  logic [1:0] dx4, dy4, sx4, sy4, st4;
  logic       busy5, v5, last5, swap5, done5;
  logic [2:0] dx5, dy5, sx5, sy5;
  logic [1:0] st5;

  bsg_acm_addr_gen #(.dim_p(4), .iter_width_p(8)) dut4 (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start4), .iters_i(iters_in),
    .busy_o(busy4), .v_o(v4), .ready_i(ready),
    .dst_x_o(dx4), .dst_y_o(dy4), .src_x_o(sx4), .src_y_o(sy4),
    .last_pixel_o(last4), .swap_o(swap4), .done_o(done4), .state_o(st4)
  );

  bsg_acm_addr_gen #(.dim_p(5), .iter_width_p(8)) dut5 (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start5), .iters_i(iters_in),
    .busy_o(busy5), .v_o(v5), .ready_i(ready),
    .dst_x_o(dx5), .dst_y_o(dy5), .src_x_o(sx5), .src_y_o(sy5),
    .last_pixel_o(last5), .swap_o(swap5), .done_o(done5), .state_o(st5)
  );

  // Observed view of the selected instance.
  logic       o_busy, o_v, o_last, o_swap, o_done;
  logic [2:0] o_dx, o_dy, o_sx, o_sy;
  logic [1:0] o_st;
  assign o_busy = sel ? busy5 : busy4;
  assign o_v    = sel ? v5    : v4;
  assign o_last = sel ? last5 : last4;
  assign o_swap = sel ? swap5 : swap4;
  assign o_done = sel ? done5 : done4;
  assign o_dx   = sel ? dx5 : {1'b0, dx4};
  assign o_dy   = sel ? dy5 : {1'b0, dy4};
  assign o_sx   = sel ? sx5 : {1'b0, sx4};
  assign o_sy   = sel ? sy5 : {1'b0, sy4};
  assign o_st   = sel ? st5 : st4;

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [11:0] exp_q[$];  // {dst_x, dst_y, src_x, src_y}, 3 bits each

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Hand-computed map values: {n, dx, dy, sx, sy}.
  int hand_tbl[5][5] = '{
    '{4, 1, 2, 3, 1},
    '{4, 3, 3, 2, 1},
    '{4, 0, 0, 0, 0},
    '{5, 4, 4, 3, 2},
    '{5, 2, 3, 0, 3}
  };

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_v"},    o_v,    0);
    check({tag, "_swap"}, o_swap, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_last"}, o_last, 0);
    check({tag, "_coords"}, {o_dx, o_dy, o_sx, o_sy}, 0);
    check({tag, "_state"}, o_st, 0);
  endtask

  // ---------------- driver: one full run ----------------
  task automatic run(input int n, input int iters, input bit rnd, input int pulse_at);
    int cyc, xfers, swaps, lasts, done_cyc;
    bit done_seen, prev_stall;
    logic [12:0] prev_out;
    logic [11:0] exp_v, act_v;
    sel = (n == 5);
    exp_q.delete();
    for (int it = 0; it < iters; it++)
      for (int y = 0; y < n; y++)
        for (int x = 0; x < n; x++)
          exp_q.push_back({3'(x), 3'(y), 3'((x + y) % n), 3'((x + 2 * y) % n)});
    xfers = 0; swaps = 0; lasts = 0; done_cyc = 0;
    done_seen = 1'b0; prev_stall = 1'b0; prev_out = '0;
    @(negedge clk);
    iters_in = 8'(iters);
    start    = 1'b1;
    ready    = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    cyc = 1;
    while (!done_seen && cyc < 2000) begin
      start = (cyc == pulse_at);
      if (cyc == pulse_at) iters_in = 8'd3;
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall)
        check("stall_stable", {o_v, o_dx, o_dy, o_sx, o_sy}, prev_out);
      if (o_v && ready) begin
        xfers++;
        act_v = {o_dx, o_dy, o_sx, o_sy};
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hfff;
        check("xfer_pair", act_v, exp_v);
        check("src_in_range", (o_sx < 3'(n)) && (o_sy < 3'(n)), 1);
        check("last_pixel", o_last, (o_dx == 3'(n - 1)) && (o_dy == 3'(n - 1)));
        if (o_last) lasts++;
        for (int h = 0; h < 5; h++)
          if (hand_tbl[h][0] == n && hand_tbl[h][1] == int'(o_dx) && hand_tbl[h][2] == int'(o_dy))
            check("hand_map", {o_sx, o_sy}, {3'(hand_tbl[h][3]), 3'(hand_tbl[h][4])});
      end
      if (o_swap) begin
        swaps++;
        check("swap_v_low", o_v, 0);
        check("swap_position", xfers, swaps * n * n);
      end
      if (o_done) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
        check("done_busy", o_busy, 1);
        check("done_v_low", o_v, 0);
      end
      prev_stall = o_v && !ready;
      prev_out   = {o_v, o_dx, o_dy, o_sx, o_sy};
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    ready = 1'b1;
    check("done_seen", done_seen, 1);
    check("xfer_count", xfers, iters * n * n);
    check("exp_q_empty", exp_q.size(), 0);
    check("swap_count", swaps, iters - 1);
    check("last_count", lasts, iters);
    if (!rnd) check("done_latency", done_cyc, iters * n * n + iters);
    check("post_done_pulse", o_done, 0);
    check("post_done_busy", o_busy, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int c;
    // Reset state of both instances.
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    sel = 1'b0; check_idle_zero("reset4");
    sel = 1'b1; check_idle_zero("reset5");
    reset_n = 1'b1;

    // N=4, one iteration, ready held high.
    run(4, 1, 1'b0, 0);
    // N=5, one iteration.
    run(5, 1, 1'b0, 0);
    // N=4, two iterations: swap placement and done latency.
    run(4, 2, 1'b0, 0);
    // N=5, two iterations with random backpressure.
    run(5, 2, 1'b1, 0);

    // Reset during the second iteration of a 3-iteration run.
    sel = 1'b0;
    @(negedge clk);
    iters_in = 8'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (c = 1; c < 20; c++) @(negedge clk);
    check("midrun_busy", o_busy, 1);
    reset_n = 1'b0;
    @(negedge clk);
    check_idle_zero("midrun_reset");
    reset_n = 1'b1;
    for (c = 0; c < 4; c++) begin
      check("midrun_no_done", o_done, 0);
      @(negedge clk);
    end
    run(4, 1, 1'b0, 0);

    // Zero iterations; a start held through the done cycle is ignored.
    sel = 1'b0;
    @(negedge clk);
    iters_in = 8'd0;
    start = 1'b1;
    @(negedge clk);
    check("zero_done", o_done, 1);
    check("zero_v", o_v, 0);
    check("zero_busy", o_busy, 1);
    iters_in = 8'd1;
    @(negedge clk);
    start = 1'b0;
    check_idle_zero("zero_after");

    // start pulsed mid-run has no effect on the sequence.
    run(4, 1, 1'b0, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bsg_acm_addr_gen.md
Name: bsg_acm_addr_gen

Overview:
- Address sequencer that sits directly upstream of the bsg_acm_cell array in the ACM decryptor.
- For each decryption iteration it sweeps the N x N destination image in raster order. For every destination pixel it emits the matching source coordinate given by the forward Arnold cat map.
- The cell array uses these pairs to perform one inverse-permutation pass per iteration.
- It emits a one-cycle swap pulse between iterations so the cell array can exchange its ping/pong buffers, and a done pulse after the final iteration.

Parameters:
- dim_p, 32, image side length N in pixels. Any value >= 2; need not be a power of two.
- iter_width_p, 8, width of the iteration-count input.
- coord_w_lp, $clog2(dim_p), local parameter: coordinate width.

Ports:
- clk_i  in  1  clock, all state updates on posedge.
- reset_n_i  in  1  synchronous, active-low reset.
- start_i  in  1  begin a decryption run. Sampled only in IDLE.
- iters_i  in  iter_width_p  number of map iterations. Latched when start_i is accepted.
- busy_o  out  1  high in every state except IDLE.
- v_o  out  1  address pair valid.
- ready_i  in  1  consumer accepts the pair. Transfer occurs when v_o & ready_i.
- dst_x_o, dst_y_o  out  coord_w_lp each  destination (raster) coordinate.
- src_x_o, src_y_o  out  coord_w_lp each  source coordinate.
- last_pixel_o  out  1  the current pair is (N-1, N-1) of this iteration.
- swap_o  out  1  one-cycle pulse between iterations.
- done_o  out  1  one-cycle pulse at end of run.

Behaviour:
- Reset (reset_n_i=0 at posedge):
  - state=IDLE; x, y and iteration counter = 0.
  - All outputs 0: busy_o, v_o, swap_o, done_o, last_pixel_o, and all coordinates.
  - Reset mid-run aborts immediately; no done_o is issued.
- States: IDLE, RUN, SWAP, DONE.
- IDLE:
  - On start_i=1, latch iters_i and clear x, y and the iteration counter.
  - If the latched count is 0, go to DONE; otherwise go to RUN.
- RUN:
  - v_o=1.
  - dst = (x, y).
  - src_x = (x + y) mod N.
  - src_y = (x + 2y) mod N.
  - src is a combinational function of the x/y registers: no extra latency, at most 3 conditional subtractions, no divider or multiplier.
  - The first pair is valid the cycle after start is accepted.
- Advance on transfer only:
  - x increments.
  - When x=N-1, x wraps to 0 and y increments.
- Transfer at (N-1, N-1), i.e. last_pixel_o=1:
  - If the iteration counter equals iters-1, go to DONE.
  - Otherwise increment the iteration counter, clear x and y, and go to SWAP.
- Backpressure: while v_o & ~ready_i, all outputs and state hold stable. No pair is dropped or duplicated.
- SWAP: exactly one cycle with swap_o=1 and v_o=0, then RUN.
- DONE: exactly one cycle with done_o=1, busy_o=1 and v_o=0, then IDLE.
- start_i is ignored outside IDLE. start_i asserted in the same cycle done_o is high is also ignored.
- Throughput with ready_i held high:
  - One pair per cycle.
  - A run of k>0 iterations takes k*N*N transfer cycles plus (k-1) SWAP cycles plus 1 DONE cycle after start.
- Arithmetic:
  - The intermediate sum needs coord_w_lp+2 bits. All results are < N.
  - Correct for non-power-of-two N (no bit truncation used as the modulo).

Test Plan:
- Reset mid-run: dim_p=4, iters=3, assert reset_n_i=0 during the second iteration -> next cycle state IDLE, all outputs 0, no done_o. A new start_i then produces dst=(0,0) first.
- Map values, dim_p=4, iters=1, ready_i=1:
  - dst (1,2) -> src (3,1).
  - dst (3,3) -> src (2,1).
  - dst (0,0) -> src (0,0).
  - Exactly 16 transfers, last_pixel_o only on (3,3), done_o one cycle later, no swap_o.
- Non-power-of-two, dim_p=5, iters=1:
  - dst (4,4) -> src (3,2).
  - dst (2,3) -> src (0,3).
  - 25 transfers, all src coordinates < 5.
- Multi-iteration, dim_p=4, iters=2, ready_i=1:
  - 32 transfers.
  - swap_o exactly once, between transfer 16 and 17, with v_o=0 that cycle.
  - done_o 34 cycles after the start cycle.
- Backpressure: random ready_i (50%), dim_p=5, iters=2 -> outputs stable while stalled. The transfer sequence is identical to the ready_i=1 run, 50 pairs total.
- Zero and ignored start:
  - iters_i=0 -> done_o pulse the cycle after start, v_o never high.
  - start_i pulsed during RUN -> no restart; the counters continue unchanged.
